// File: rtl/bcpu_barrel_decoder_pkg.sv
// rtl/bcpu_barrel_decoder_pkg.sv - BCPU16 decoder definitions: opcodes, enums, decoded bundle, constant/condition helpers
package bcpu_barrel_decoder_pkg;

  localparam int BCPU_DATA_WIDTH      = 16;
  localparam int BCPU_INSTR_WIDTH     = 16;
  localparam int BCPU_PC_WIDTH        = 10;
  localparam int BCPU_ADDR_WIDTH      = 10;
  localparam int BCPU_REG_INDEX_WIDTH = 3;
  localparam int BCPU_THREAD_ID_WIDTH = 2;
  localparam int BCPU_BUS_ADDR_WIDTH  = 3;
  localparam int BCPU_BUS_OP_WIDTH    = 2;
  localparam int BCPU_ALU_OP_WIDTH    = 4;

  localparam int PREFIX_WIDTH = 11;

  // ALU opcode slots reserved for non-ALU instructions when bit15=0
  localparam logic [3:0] INSTR_PREFIX = 4'b0010;
  localparam logic [3:0] INSTR_BUS    = 4'b0011;

  typedef enum logic [1:0] {
    REG_WRITE_FROM_ALU = 2'b00,
    REG_WRITE_FROM_BUS = 2'b01,
    REG_WRITE_FROM_JMP = 2'b10,
    REG_WRITE_FROM_MEM = 2'b11
  } reg_write_src_e;

  typedef enum logic [1:0] {
    BUSOP_READ     = 2'b00,
    BUSOP_WRITE    = 2'b01,
    BUSOP_READ_IRQ = 2'b10,
    BUSOP_WAIT     = 2'b11
  } bus_op_e;

  typedef struct packed {
    logic                            valid;
    logic [BCPU_THREAD_ID_WIDTH-1:0] thread_id;
    logic [BCPU_DATA_WIDTH-1:0]      b_value;
    logic [BCPU_ADDR_WIDTH-1:0]      addr_value;
    logic [BCPU_REG_INDEX_WIDTH-1:0] dst_reg_index;
    reg_write_src_e                  dst_reg_source;
    logic                            dst_reg_wren;
    logic                            alu_en;
    logic                            bus_rd_en;
    logic                            bus_wr_en;
    logic                            mem_en;
    logic                            mem_write_en;
    logic                            jmp_en;
    logic [BCPU_ALU_OP_WIDTH-1:0]    alu_op;
    logic [BCPU_BUS_OP_WIDTH-1:0]    bus_op;
    logic [BCPU_BUS_ADDR_WIDTH-1:0]  bus_addr;
    logic                            prefix_used;
  } decoded_instr_t;

  // Rb-slot constants: 01 -> 1<<idx, 10 -> 256<<idx, 11 -> -1-idx
  function automatic logic [15:0] breg_const(input logic [1:0] mode, input logic [2:0] idx);
    logic [15:0] c;
    case (mode)
      2'b01:   c = 16'h0001 << idx;
      2'b10:   c = 16'h0100 << idx;
      2'b11:   c = 16'hFFFF - {13'd0, idx};
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  // flags = {V,S,Z,C}
  function automatic logic cond_met(input logic [3:0] cccc, input logic [3:0] flags);
    logic v, s, z, c, r;
    {v, s, z, c} = flags;
    case (cccc)
      4'h0: r = 1'b1;
      4'h1: r = !c;
      4'h2: r = c;
      4'h3: r = !z;
      4'h4: r = z;
      4'h5: r = !s;
      4'h6: r = s;
      4'h7: r = !v;
      4'h8: r = v;
      4'h9: r = !c && !z;
      4'hA: r = c || z;
      4'hB: r = (s == v);
      4'hC: r = (s != v);
      4'hD: r = !z && (s == v);
      4'hE: r = z || (s != v);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcpu_barrel_decoder_if.sv
// rtl/bcpu_barrel_decoder_if.sv - instruction-in / decoded-out bundle of the barrel decoder
interface bcpu_barrel_decoder_if #(
  parameter int DATA_WIDTH      = 16,
  parameter int INSTR_WIDTH     = 16,
  parameter int PC_WIDTH        = 10,
  parameter int ADDR_WIDTH      = 10,
  parameter int REG_INDEX_WIDTH = 3,
  parameter int THREAD_ID_WIDTH = 2,
  parameter int BUS_ADDR_WIDTH  = 3,
  parameter int BUS_OP_WIDTH    = 2,
  parameter int ALU_OP_WIDTH    = 4
);
  logic                       IN_VALID;
  logic [THREAD_ID_WIDTH-1:0] IN_THREAD_ID;
  logic [INSTR_WIDTH-1:0]     INSTR_IN;
  logic [PC_WIDTH-1:0]        PC_IN;
  logic [3:0]                 FLAGS_IN;
  logic [REG_INDEX_WIDTH-1:0] A_INDEX;
  logic [REG_INDEX_WIDTH-1:0] B_INDEX;
  logic [DATA_WIDTH-1:0]      B_VALUE_IN;
  logic                       FLUSH;
  logic [THREAD_ID_WIDTH-1:0] FLUSH_THREAD_ID;

  logic                       OUT_VALID;
  logic [THREAD_ID_WIDTH-1:0] OUT_THREAD_ID;
  logic [DATA_WIDTH-1:0]      B_VALUE_OUT;
  logic [ADDR_WIDTH-1:0]      ADDR_VALUE;
  logic [REG_INDEX_WIDTH-1:0] DST_REG_INDEX;
  logic [1:0]                 DST_REG_SOURCE;
  logic                       DST_REG_WREN;
  logic                       ALU_EN;
  logic                       BUS_RD_EN;
  logic                       BUS_WR_EN;
  logic                       MEM_EN;
  logic                       MEM_WRITE_EN;
  logic                       JMP_EN;
  logic [ALU_OP_WIDTH-1:0]    ALU_OP;
  logic [BUS_OP_WIDTH-1:0]    BUS_OP;
  logic [BUS_ADDR_WIDTH-1:0]  BUS_ADDR;
  logic                       PREFIX_USED;

  modport master (
    output IN_VALID, IN_THREAD_ID, INSTR_IN, PC_IN, FLAGS_IN, B_VALUE_IN, FLUSH, FLUSH_THREAD_ID,
    input  A_INDEX, B_INDEX, OUT_VALID, OUT_THREAD_ID, B_VALUE_OUT, ADDR_VALUE, DST_REG_INDEX,
           DST_REG_SOURCE, DST_REG_WREN, ALU_EN, BUS_RD_EN, BUS_WR_EN, MEM_EN, MEM_WRITE_EN,
           JMP_EN, ALU_OP, BUS_OP, BUS_ADDR, PREFIX_USED
  );

  modport slave (
    input  IN_VALID, IN_THREAD_ID, INSTR_IN, PC_IN, FLAGS_IN, B_VALUE_IN, FLUSH, FLUSH_THREAD_ID,
    output A_INDEX, B_INDEX, OUT_VALID, OUT_THREAD_ID, B_VALUE_OUT, ADDR_VALUE, DST_REG_INDEX,
           DST_REG_SOURCE, DST_REG_WREN, ALU_EN, BUS_RD_EN, BUS_WR_EN, MEM_EN, MEM_WRITE_EN,
           JMP_EN, ALU_OP, BUS_OP, BUS_ADDR, PREFIX_USED
  );
endinterface

// File: rtl/bcpu_barrel_decoder_prefix_regs.sv
// rtl/bcpu_barrel_decoder_prefix_regs.sv - bcpu_thread_prefix_regs: per-thread immediate prefix value/valid store
module bcpu_thread_prefix_regs #(
  parameter int THREAD_ID_WIDTH = 2,
  parameter int PREFIX_WIDTH    = 11,
  parameter bit ENABLE          = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [THREAD_ID_WIDTH-1:0] thread_id,
  output logic [PREFIX_WIDTH-1:0]    rd_prefix,
  output logic                       rd_valid,
  input  logic                       set_en,
  input  logic [PREFIX_WIDTH-1:0]    set_value,
  input  logic                       consume_en,
  input  logic                       flush_en,
  input  logic [THREAD_ID_WIDTH-1:0] flush_thread_id
);
  localparam int NUM_THREADS = 1 << THREAD_ID_WIDTH;

  if (ENABLE) begin : g_store
    logic [PREFIX_WIDTH-1:0] prefix_q [NUM_THREADS];
    logic [NUM_THREADS-1:0]  valid_q;

    // flush beats a same-cycle set or consume of the same thread
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= '0;
        for (int t = 0; t < NUM_THREADS; t++) prefix_q[t] <= '0;
      end else begin
        for (int t = 0; t < NUM_THREADS; t++) begin
          if (flush_en && flush_thread_id == THREAD_ID_WIDTH'(t)) begin
            valid_q[t] <= 1'b0;
          end else if (set_en && thread_id == THREAD_ID_WIDTH'(t)) begin
            valid_q[t]  <= 1'b1;
            prefix_q[t] <= set_value;
          end else if (consume_en && thread_id == THREAD_ID_WIDTH'(t)) begin
            valid_q[t] <= 1'b0;
          end
        end
      end
    end

    assign rd_prefix = prefix_q[thread_id];
    assign rd_valid  = valid_q[thread_id];
  end else begin : g_none
    logic unused_ok;
    assign unused_ok = ^{clk, rst, thread_id, set_en, set_value, consume_en, flush_en, flush_thread_id};
    assign rd_prefix = '0;
    assign rd_valid  = 1'b0;
  end

endmodule

// File: rtl/bcpu_barrel_decoder.sv
// rtl/bcpu_barrel_decoder.sv - registered multi-thread BCPU16 decoder; BCPU_IMM_PREFIX_EN enables immediate PREFIX
module bcpu_barrel_decoder
  import bcpu_barrel_decoder_pkg::*;
#(
  parameter int DATA_WIDTH      = BCPU_DATA_WIDTH,
  parameter int INSTR_WIDTH     = BCPU_INSTR_WIDTH,
  parameter int PC_WIDTH        = BCPU_PC_WIDTH,
  parameter int ADDR_WIDTH      = BCPU_ADDR_WIDTH,
  parameter int REG_INDEX_WIDTH = BCPU_REG_INDEX_WIDTH,
  parameter int THREAD_ID_WIDTH = BCPU_THREAD_ID_WIDTH,
  parameter int BUS_ADDR_WIDTH  = BCPU_BUS_ADDR_WIDTH,
  parameter int BUS_OP_WIDTH    = BCPU_BUS_OP_WIDTH,
  parameter int ALU_OP_WIDTH    = BCPU_ALU_OP_WIDTH
) (
  input logic                 CLK,
  input logic                 RESET,
  bcpu_barrel_decoder_if.slave dec
);
`ifdef BCPU_IMM_PREFIX_EN
  localparam bit PREFIX_EN = 1'b1;
`else
  localparam bit PREFIX_EN = 1'b0;
`endif

  logic [15:0] instr;
  logic        is_alu, is_bus, is_prefix, is_mem, is_cjmp, is_call, is_jmp;
  logic        flush_hit, pf_valid, pf_live, pf_set, pf_consume;
  logic [PREFIX_WIDTH-1:0]    pf_prefix;
  logic [ADDR_WIDTH-1:0]      base_rb, base_pc, off_rb5, off_pfx, off_pc8, off_pc13;
  logic [REG_INDEX_WIDTH-1:0] dst;
  decoded_instr_t             d, q;

  assign instr = dec.INSTR_IN[15:0];

  assign is_prefix = !instr[15] && instr[14:11] == INSTR_PREFIX;
  assign is_bus    = !instr[15] && instr[14:11] == INSTR_BUS;
  assign is_alu    = !instr[15] && !is_prefix && !is_bus;
  assign is_mem    = instr[15:13] == 3'b100;
  assign is_cjmp   = instr[15:13] == 3'b101;
  assign is_call   = instr[15:13] == 3'b110;
  assign is_jmp    = instr[15:13] == 3'b111;

  assign dec.A_INDEX = instr[10:8];
  assign dec.B_INDEX = instr[7:5];

  // A flush aimed at the incoming thread hides its prefix this very cycle
  assign flush_hit  = dec.FLUSH && dec.FLUSH_THREAD_ID == dec.IN_THREAD_ID;
  assign pf_live    = pf_valid && !flush_hit;
  assign pf_set     = dec.IN_VALID && is_prefix && !flush_hit;
  assign pf_consume = dec.IN_VALID && !is_prefix;

  bcpu_thread_prefix_regs #(
    .THREAD_ID_WIDTH(THREAD_ID_WIDTH),
    .PREFIX_WIDTH   (PREFIX_WIDTH),
    .ENABLE         (PREFIX_EN)
  ) u_prefix_regs (
    .clk            (CLK),
    .rst            (RESET),
    .thread_id      (dec.IN_THREAD_ID),
    .rd_prefix      (pf_prefix),
    .rd_valid       (pf_valid),
    .set_en         (pf_set),
    .set_value      (instr[10:0]),
    .consume_en     (pf_consume),
    .flush_en       (dec.FLUSH),
    .flush_thread_id(dec.FLUSH_THREAD_ID)
  );

  // Signed size casts sign-extend/truncate offsets; sums wrap at 2^ADDR_WIDTH
  assign base_rb  = ADDR_WIDTH'(dec.B_VALUE_IN);
  assign base_pc  = ADDR_WIDTH'(dec.PC_IN);
  assign off_rb5  = ADDR_WIDTH'($signed(instr[4:0]));
  assign off_pfx  = ADDR_WIDTH'($signed({pf_prefix, instr[4:0]}));
  assign off_pc8  = ADDR_WIDTH'($signed(instr[7:0]));
  assign off_pc13 = ADDR_WIDTH'($signed(instr[12:0]));

  assign dst = is_alu ? instr[2:0] : (is_call ? 3'd7 : instr[10:8]);

  always_comb begin
    d = '0;
    if (dec.IN_VALID) begin
      d.valid         = 1'b1;
      d.thread_id     = dec.IN_THREAD_ID;
      d.alu_op        = instr[14:11];
      d.bus_op        = instr[4:3];
      d.bus_addr      = instr[2:0];
      d.dst_reg_index = dst;
      d.alu_en        = is_alu;
      d.bus_wr_en     = is_bus && instr[4:3] == BUSOP_WRITE;
      d.bus_rd_en     = is_bus && instr[4:3] != BUSOP_WRITE;
      d.mem_en        = is_mem;
      d.mem_write_en  = is_mem && instr[11];
      d.jmp_en        = is_call || is_jmp || (is_cjmp && cond_met(instr[11:8], dec.FLAGS_IN));
      d.dst_reg_wren  = (is_alu || (is_mem && !instr[11]) || d.bus_rd_en || is_call) && dst != '0;

      if (is_alu)                         d.dst_reg_source = REG_WRITE_FROM_ALU;
      else if (is_mem)                    d.dst_reg_source = REG_WRITE_FROM_MEM;
      else if (is_cjmp || is_call || is_jmp) d.dst_reg_source = REG_WRITE_FROM_JMP;
      else                                d.dst_reg_source = REG_WRITE_FROM_BUS;

      d.b_value = dec.B_VALUE_IN;
      if (is_alu && instr[4:3] != 2'b00) begin
        if (pf_live) begin
          d.b_value     = DATA_WIDTH'({pf_prefix, instr[7:3]});
          d.prefix_used = 1'b1;
        end else begin
          d.b_value = DATA_WIDTH'(breg_const(instr[4:3], instr[7:5]));
        end
      end

      if (is_mem || is_cjmp) begin
        if (instr[12]) begin
          d.addr_value = base_pc + off_pc8;
        end else if (is_mem && pf_live) begin
          d.addr_value  = base_rb + off_pfx;
          d.prefix_used = 1'b1;
        end else begin
          d.addr_value = base_rb + off_rb5;
        end
      end else if (is_call || is_jmp) begin
        d.addr_value = base_pc + off_pc13;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) q <= '0;
    else       q <= d;
  end

  assign dec.OUT_VALID      = q.valid;
  assign dec.OUT_THREAD_ID  = q.thread_id;
  assign dec.B_VALUE_OUT    = q.b_value;
  assign dec.ADDR_VALUE     = q.addr_value;
  assign dec.DST_REG_INDEX  = q.dst_reg_index;
  assign dec.DST_REG_SOURCE = q.dst_reg_source;
  assign dec.DST_REG_WREN   = q.dst_reg_wren;
  assign dec.ALU_EN         = q.alu_en;
  assign dec.BUS_RD_EN      = q.bus_rd_en;
  assign dec.BUS_WR_EN      = q.bus_wr_en;
  assign dec.MEM_EN         = q.mem_en;
  assign dec.MEM_WRITE_EN   = q.mem_write_en;
  assign dec.JMP_EN         = q.jmp_en;
  assign dec.ALU_OP         = q.alu_op;
  assign dec.BUS_OP         = q.bus_op;
  assign dec.BUS_ADDR       = q.bus_addr;
  assign dec.PREFIX_USED    = q.prefix_used;

endmodule

// File: tb/tb_bcpu_barrel_decoder.sv
// tb/tb_bcpu_barrel_decoder.sv - directed self-checking bench for bcpu_barrel_decoder
module tb_bcpu_barrel_decoder;
  import bcpu_barrel_decoder_pkg::*;

`ifdef BCPU_IMM_PREFIX_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  // ALU 0x22A9 (imm mode 01, Rb slot 5): prefix 0x123 form or table constant 1<<5
  localparam logic [15:0] B_TABLE = 16'h0020;
  localparam logic [15:0] B_PFX   = PF ? 16'h2475 : 16'h0020;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcpu_barrel_decoder_if dif ();

  bcpu_barrel_decoder dut (
    .CLK  (clk),
    .RESET(rst),
    .dec  (dif)
  );

  task automatic drive(input logic v, input logic [1:0] tid, input logic [15:0] ins,
                       input logic [9:0] pc, input logic [15:0] b, input logic [3:0] flags,
                       input logic fl, input logic [1:0] ftid);
    dif.IN_VALID        = v;
    dif.IN_THREAD_ID    = tid;
    dif.INSTR_IN        = ins;
    dif.PC_IN           = pc;
    dif.B_VALUE_IN      = b;
    dif.FLAGS_IN        = flags;
    dif.FLUSH           = fl;
    dif.FLUSH_THREAD_ID = ftid;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    dif.IN_VALID = 1'b1; dif.IN_THREAD_ID = 2'd0; dif.INSTR_IN = 16'h22A9; dif.PC_IN = '0;
    dif.B_VALUE_IN = 16'h1234; dif.FLAGS_IN = '0; dif.FLUSH = 1'b0; dif.FLUSH_THREAD_ID = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dif.OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", dif.OUT_VALID); end
    checks++; if (dif.B_VALUE_OUT !== 16'h0) begin errors++; $display("FAIL rst_b got %h want 0000", dif.B_VALUE_OUT); end
    checks++; if ({dif.ALU_EN, dif.DST_REG_WREN, dif.PREFIX_USED} !== 3'b000) begin errors++; $display("FAIL rst_en got %b want 000", {dif.ALU_EN, dif.DST_REG_WREN, dif.PREFIX_USED}); end
    checks++; if ({dif.A_INDEX, dif.B_INDEX} !== 6'b010_101) begin errors++; $display("FAIL ab_index got %b want 010101", {dif.A_INDEX, dif.B_INDEX}); end
    rst = 1'b0;
    drive(1'b0, 2'd0, 16'h0000, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
  endtask

  task automatic test_prefix_alu;
    drive(1'b1, 2'd1, 16'h1123, 10'h0, 16'h5555, 4'h0, 1'b0, 2'd0);
    checks++; if (dif.OUT_VALID !== 1'b1) begin errors++; $display("FAIL pfx_valid got %b want 1", dif.OUT_VALID); end
    checks++; if ({dif.ALU_EN, dif.BUS_RD_EN, dif.BUS_WR_EN, dif.MEM_EN, dif.JMP_EN, dif.DST_REG_WREN} !== 6'b0) begin errors++; $display("FAIL pfx_enables got %b want 000000", {dif.ALU_EN, dif.BUS_RD_EN, dif.BUS_WR_EN, dif.MEM_EN, dif.JMP_EN, dif.DST_REG_WREN}); end
    drive(1'b1, 2'd1, 16'h22A9, 10'h0, 16'h5555, 4'h0, 1'b0, 2'd0);
    checks++; if (dif.B_VALUE_OUT !== B_PFX) begin errors++; $display("FAIL pfx_alu_b got %h want %h", dif.B_VALUE_OUT, B_PFX); end
    checks++; if (dif.PREFIX_USED !== PF) begin errors++; $display("FAIL pfx_alu_used got %b want %b", dif.PREFIX_USED, PF); end
    checks++; if ({dif.ALU_EN, dif.DST_REG_INDEX, dif.DST_REG_WREN, dif.OUT_THREAD_ID, dif.ALU_OP} !== {1'b1, 3'd1, 1'b1, 2'd1, 4'd4}) begin errors++; $display("FAIL pfx_alu_ctl got %b want %b", {dif.ALU_EN, dif.DST_REG_INDEX, dif.DST_REG_WREN, dif.OUT_THREAD_ID, dif.ALU_OP}, {1'b1, 3'd1, 1'b1, 2'd1, 4'd4}); end
    checks++; if (dif.DST_REG_SOURCE !== REG_WRITE_FROM_ALU) begin errors++; $display("FAIL pfx_alu_src got %0d want %0d", dif.DST_REG_SOURCE, REG_WRITE_FROM_ALU); end
    drive(1'b1, 2'd1, 16'h22A9, 10'h0, 16'h5555, 4'h0, 1'b0, 2'd0);
    checks++; if ({dif.B_VALUE_OUT, dif.PREFIX_USED} !== {B_TABLE, 1'b0}) begin errors++; $display("FAIL pfx_consumed got %h/%b want %h/0", dif.B_VALUE_OUT, dif.PREFIX_USED, B_TABLE); end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 2'd0, 16'h1123, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    drive(1'b1, 2'd1, 16'h22A9, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    checks++; if ({dif.OUT_THREAD_ID, dif.B_VALUE_OUT, dif.PREFIX_USED} !== {2'd1, B_TABLE, 1'b0}) begin errors++; $display("FAIL b2b_other got %h/%h/%b want 1/%h/0", dif.OUT_THREAD_ID, dif.B_VALUE_OUT, dif.PREFIX_USED, B_TABLE); end
    drive(1'b1, 2'd0, 16'h22A9, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    checks++; if ({dif.OUT_THREAD_ID, dif.B_VALUE_OUT, dif.PREFIX_USED} !== {2'd0, B_PFX, PF}) begin errors++; $display("FAIL b2b_owner got %h/%h/%b want 0/%h/%b", dif.OUT_THREAD_ID, dif.B_VALUE_OUT, dif.PREFIX_USED, B_PFX, PF); end
  endtask

  task automatic test_alu_modes;
    drive(1'b1, 2'd0, 16'h22B9, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    checks++; if (dif.B_VALUE_OUT !== 16'hFFFA) begin errors++; $display("FAIL const_m11 got %h want fffa", dif.B_VALUE_OUT); end
    drive(1'b1, 2'd0, 16'h22B1, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    checks++; if (dif.B_VALUE_OUT !== 16'h2000) begin errors++; $display("FAIL const_m10 got %h want 2000", dif.B_VALUE_OUT); end
    drive(1'b1, 2'd0, 16'h2205, 10'h0, 16'hBEEF, 4'h0, 1'b0, 2'd0);
    checks++; if ({dif.B_VALUE_OUT, dif.DST_REG_INDEX} !== {16'hBEEF, 3'd5}) begin errors++; $display("FAIL alu_rb got %h/%0d want beef/5", dif.B_VALUE_OUT, dif.DST_REG_INDEX); end
  endtask

  task automatic test_prefix_mem;
    drive(1'b1, 2'd2, 16'h1001, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    drive(1'b1, 2'd2, 16'h8344, 10'h0, 16'h0100, 4'h0, 1'b0, 2'd0);
    checks++; if (dif.ADDR_VALUE !== (PF ? 10'h124 : 10'h104)) begin errors++; $display("FAIL mem_pfx_addr got %h want %h", dif.ADDR_VALUE, PF ? 10'h124 : 10'h104); end
    checks++; if ({dif.MEM_EN, dif.MEM_WRITE_EN, dif.DST_REG_INDEX, dif.DST_REG_WREN, dif.PREFIX_USED} !== {1'b1, 1'b0, 3'd3, 1'b1, PF}) begin errors++; $display("FAIL mem_pfx_ctl got %b want %b", {dif.MEM_EN, dif.MEM_WRITE_EN, dif.DST_REG_INDEX, dif.DST_REG_WREN, dif.PREFIX_USED}, {1'b1, 1'b0, 3'd3, 1'b1, PF}); end
    checks++; if (dif.DST_REG_SOURCE !== REG_WRITE_FROM_MEM) begin errors++; $display("FAIL mem_src got %0d want %0d", dif.DST_REG_SOURCE, REG_WRITE_FROM_MEM); end
    drive(1'b1, 2'd2, 16'h8B5F, 10'h0, 16'h0000, 4'h0, 1'b0, 2'd0);
    checks++; if ({dif.ADDR_VALUE, dif.MEM_WRITE_EN, dif.DST_REG_WREN, dif.PREFIX_USED} !== {10'h3FF, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL mem_store_wrap got %h/%b/%b/%b want 3ff/1/0/0", dif.ADDR_VALUE, dif.MEM_WRITE_EN, dif.DST_REG_WREN, dif.PREFIX_USED); end
    drive(1'b1, 2'd0, 16'h17FF, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    drive(1'b1, 2'd0, 16'h8340, 10'h0, 16'h0010, 4'h0, 1'b0, 2'd0);
    checks++; if (dif.ADDR_VALUE !== (PF ? 10'h3F0 : 10'h010)) begin errors++; $display("FAIL mem_pfx_neg got %h want %h", dif.ADDR_VALUE, PF ? 10'h3F0 : 10'h010); end
  endtask

  task automatic test_flush;
    drive(1'b1, 2'd3, 16'h1123, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    drive(1'b0, 2'd0, 16'h0000, 10'h0, 16'h0, 4'h0, 1'b1, 2'd3);
    checks++; if (dif.OUT_VALID !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", dif.OUT_VALID); end
    drive(1'b1, 2'd3, 16'h22A9, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    checks++; if ({dif.B_VALUE_OUT, dif.PREFIX_USED} !== {B_TABLE, 1'b0}) begin errors++; $display("FAIL flush_idle got %h/%b want %h/0", dif.B_VALUE_OUT, dif.PREFIX_USED, B_TABLE); end
    drive(1'b1, 2'd3, 16'h1123, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    drive(1'b1, 2'd3, 16'h22A9, 10'h0, 16'h0, 4'h0, 1'b1, 2'd3);
    checks++; if ({dif.B_VALUE_OUT, dif.PREFIX_USED} !== {B_TABLE, 1'b0}) begin errors++; $display("FAIL flush_same got %h/%b want %h/0", dif.B_VALUE_OUT, dif.PREFIX_USED, B_TABLE); end
    drive(1'b1, 2'd3, 16'h1123, 10'h0, 16'h0, 4'h0, 1'b1, 2'd3);
    drive(1'b1, 2'd3, 16'h22A9, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    checks++; if (dif.PREFIX_USED !== 1'b0) begin errors++; $display("FAIL flush_drop_pfx got %b want 0", dif.PREFIX_USED); end
    drive(1'b1, 2'd0, 16'h1123, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    drive(1'b1, 2'd1, 16'h22A9, 10'h0, 16'h0, 4'h0, 1'b1, 2'd1);
    drive(1'b1, 2'd0, 16'h22A9, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    checks++; if ({dif.B_VALUE_OUT, dif.PREFIX_USED} !== {B_PFX, PF}) begin errors++; $display("FAIL flush_other got %h/%b want %h/%b", dif.B_VALUE_OUT, dif.PREFIX_USED, B_PFX, PF); end
  endtask

  task automatic test_reset_midstream;
    drive(1'b1, 2'd3, 16'h1123, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    rst = 1'b1;
    #1;
    checks++; if (dif.OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_async got %b want 0", dif.OUT_VALID); end
    #2;
    rst = 1'b0;
    drive(1'b0, 2'd3, 16'h22A9, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    checks++; if (dif.OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_idle got %b want 0", dif.OUT_VALID); end
    drive(1'b1, 2'd3, 16'h22A9, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    checks++; if ({dif.OUT_VALID, dif.B_VALUE_OUT, dif.PREFIX_USED} !== {1'b1, B_TABLE, 1'b0}) begin errors++; $display("FAIL rst_cleared got %b/%h/%b want 1/%h/0", dif.OUT_VALID, dif.B_VALUE_OUT, dif.PREFIX_USED, B_TABLE); end
  endtask

  task automatic test_jumps;
    drive(1'b1, 2'd1, 16'hC005, 10'h3FE, 16'h0, 4'h0, 1'b0, 2'd0);
    checks++; if ({dif.ADDR_VALUE, dif.JMP_EN, dif.DST_REG_INDEX, dif.DST_REG_WREN} !== {10'h003, 1'b1, 3'd7, 1'b1}) begin errors++; $display("FAIL call got %h/%b/%0d/%b want 003/1/7/1", dif.ADDR_VALUE, dif.JMP_EN, dif.DST_REG_INDEX, dif.DST_REG_WREN); end
    checks++; if (dif.DST_REG_SOURCE !== REG_WRITE_FROM_JMP) begin errors++; $display("FAIL call_src got %0d want %0d", dif.DST_REG_SOURCE, REG_WRITE_FROM_JMP); end
    drive(1'b1, 2'd1, 16'hFFFE, 10'h001, 16'h0, 4'h0, 1'b0, 2'd0);
    checks++; if ({dif.ADDR_VALUE, dif.JMP_EN, dif.DST_REG_WREN} !== {10'h3FF, 1'b1, 1'b0}) begin errors++; $display("FAIL jmp_back got %h/%b/%b want 3ff/1/0", dif.ADDR_VALUE, dif.JMP_EN, dif.DST_REG_WREN); end
    drive(1'b1, 2'd2, 16'hB410, 10'h100, 16'h0, 4'b0000, 1'b0, 2'd0);
    checks++; if ({dif.ADDR_VALUE, dif.JMP_EN} !== {10'h110, 1'b0}) begin errors++; $display("FAIL cjmp_z_unmet got %h/%b want 110/0", dif.ADDR_VALUE, dif.JMP_EN); end
    drive(1'b1, 2'd2, 16'hB410, 10'h100, 16'h0, 4'b0010, 1'b0, 2'd0);
    checks++; if (dif.JMP_EN !== 1'b1) begin errors++; $display("FAIL cjmp_z_met got %b want 1", dif.JMP_EN); end
    drive(1'b1, 2'd2, 16'hBB01, 10'h100, 16'h0, 4'b0100, 1'b0, 2'd0);
    checks++; if (dif.JMP_EN !== 1'b0) begin errors++; $display("FAIL cjmp_ge got %b want 0", dif.JMP_EN); end
    drive(1'b1, 2'd2, 16'hA043, 10'h100, 16'h0200, 4'h0, 1'b0, 2'd0);
    checks++; if ({dif.ADDR_VALUE, dif.JMP_EN} !== {10'h203, 1'b1}) begin errors++; $display("FAIL cjmp_rb got %h/%b want 203/1", dif.ADDR_VALUE, dif.JMP_EN); end
  endtask

  task automatic test_bus_and_r0;
    drive(1'b1, 2'd0, 16'h190D, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    checks++; if ({dif.BUS_WR_EN, dif.BUS_RD_EN, dif.DST_REG_WREN, dif.BUS_OP, dif.BUS_ADDR} !== {1'b1, 1'b0, 1'b0, 2'd1, 3'd5}) begin errors++; $display("FAIL bus_wr got %b want 100_01_101", {dif.BUS_WR_EN, dif.BUS_RD_EN, dif.DST_REG_WREN, dif.BUS_OP, dif.BUS_ADDR}); end
    drive(1'b1, 2'd0, 16'h1A03, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    checks++; if ({dif.BUS_WR_EN, dif.BUS_RD_EN, dif.DST_REG_WREN, dif.DST_REG_INDEX} !== {1'b0, 1'b1, 1'b1, 3'd2}) begin errors++; $display("FAIL bus_rd got %b want 011_010", {dif.BUS_WR_EN, dif.BUS_RD_EN, dif.DST_REG_WREN, dif.DST_REG_INDEX}); end
    checks++; if (dif.DST_REG_SOURCE !== REG_WRITE_FROM_BUS) begin errors++; $display("FAIL bus_src got %0d want %0d", dif.DST_REG_SOURCE, REG_WRITE_FROM_BUS); end
    drive(1'b0, 2'd0, 16'h22A9, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    checks++; if ({dif.OUT_VALID, dif.ALU_EN} !== 2'b00) begin errors++; $display("FAIL gap got %b want 00", {dif.OUT_VALID, dif.ALU_EN}); end
    drive(1'b1, 2'd0, 16'h22A8, 10'h0, 16'h0, 4'h0, 1'b0, 2'd0);
    checks++; if ({dif.ALU_EN, dif.DST_REG_WREN} !== 2'b10) begin errors++; $display("FAIL alu_r0 got %b want 10", {dif.ALU_EN, dif.DST_REG_WREN}); end
  endtask

  initial begin
    test_reset();
    test_prefix_alu();
    test_back_to_back();
    test_alu_modes();
    test_prefix_mem();
    test_flush();
    test_reset_midstream();
    test_jumps();
    test_bus_and_r0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
